codec_i2c_seq: RTL

- Hardware I2C master and sequencer for the WM8750 codec control port. Replaces GPIO bit-banging of codec_scl/codec_sda.
- On start_i, it walks an external init table of register writes and issues one 3-byte I2C write per entry.
- Between sequences it accepts single register writes from the CPU through a valid/ready port.
- Sits between fpga_top GPIO/peripheral space and the codec_scl/codec_sda open-drain pads.

---
 rtl/codec_i2c_seq.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/codec_i2c_seq.sv
// codec_i2c_seq: I2C master and init-table sequencer for the WM8750 control port.
//
// Each transaction is one 3-byte write: {DEV_ADDR,0}, {reg[6:0],data[8]}, data[7:0].
// start_i walks the external init table (tbl_idx_o / tbl_data_i) from entry 0.
// Between sequences the CPU can issue single writes through req_valid_i/req_ready_o.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  pulse: run the init table sequence
//   tbl_idx_o, tbl_data_i    table index out; entry {reg,data} valid 1 cycle later
//   req_valid_i/req_ready_o  CPU single-write handshake, with req_reg_i, req_data_i
//   busy_o, done_o, err_o    status: in progress, end pulse, sticky NACK
//   scl_i, sda_i             pad inputs
//   scl_oe_o, sda_oe_o       open-drain enables (1 pulls the line low)
//
// Build option: define CODEC_I2C_STRETCH_EN to honour slave clock stretching
// (the quarter counter holds while SCL is released but still reads low).
module codec_i2c_seq #(
  parameter int unsigned CLK_FREQ = 32000000,
  parameter int unsigned I2C_FREQ = 100000,
  parameter logic [6:0]  DEV_ADDR = 7'h1A,
  parameter int unsigned TBL_LEN  = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic [7:0]  tbl_idx_o,
  input  logic [15:0] tbl_data_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [6:0]  req_reg_i,
  input  logic [8:0]  req_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        scl_oe_o,
  output logic        sda_oe_o
);

  localparam int unsigned   QDIV  = CLK_FREQ / (4 * I2C_FREQ);
  localparam int unsigned   QW    = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_BIT, S_ACK, S_STOP, S_NEXT
  } state_t;

  state_t        state;
  logic [QW-1:0] qcnt;
  logic [1:0]    q;          // quarter within the current START/bit/ACK/STOP slot
  logic [23:0]   shreg;      // frame, MSB out first
  logic [2:0]    bitn;
  logic [1:0]    byten;
  logic          seq;
  logic          abort;
  logic          fetch_wait;
  logic          stretch_hold;
  logic          line_state;
  logic          tick;

`ifdef CODEC_I2C_STRETCH_EN
  // SCL is released exactly when scl_oe_o is low; a low pad means a slave is stretching.
  assign stretch_hold = ~scl_oe_o & ~scl_i;
`else
  logic unused_scl;
  assign unused_scl   = scl_i;
  assign stretch_hold = 1'b0;
`endif

  assign line_state  = state inside {S_START, S_BIT, S_ACK, S_STOP};
  assign tick        = line_state && (qcnt == QLAST) && !stretch_hold;
  assign req_ready_o = (state == S_IDLE) && !start_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      qcnt       <= '0;
      q          <= '0;
      shreg      <= '0;
      bitn       <= '0;
      byten      <= '0;
      seq        <= 1'b0;
      abort      <= 1'b0;
      fetch_wait <= 1'b0;
      tbl_idx_o  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      scl_oe_o   <= 1'b0;
      sda_oe_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;

      if (!line_state) begin
        qcnt <= '0;
        q    <= '0;
      end else if (!stretch_hold) begin
        qcnt <= tick ? '0 : qcnt + 1'b1;
        if (tick) q <= q + 2'd1;
      end

      // Line outputs are updated on the tick that ends a quarter, i.e. they
      // take the value belonging to the quarter that starts next.
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            state      <= S_FETCH;
            tbl_idx_o  <= '0;
            err_o      <= 1'b0;
            seq        <= 1'b1;
            busy_o     <= 1'b1;
            fetch_wait <= 1'b1;
          end else if (req_valid_i) begin
            state  <= S_START;
            shreg  <= {DEV_ADDR, 1'b0, req_reg_i, req_data_i};
            err_o  <= 1'b0;
            seq    <= 1'b0;
            busy_o <= 1'b1;
          end
        end
        S_FETCH: begin
          if (fetch_wait) begin
            fetch_wait <= 1'b0;
          end else begin
            shreg <= {DEV_ADDR, 1'b0, tbl_data_i};
            state <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            unique case (q)
              2'd0: sda_oe_o <= 1'b1;
              2'd1: scl_oe_o <= 1'b1;
              2'd2: ;
              2'd3: begin
                state    <= S_BIT;
                sda_oe_o <= ~shreg[23];
              end
            endcase
          end
        end
        S_BIT: begin
          if (tick) begin
            unique case (q)
              2'd0: scl_oe_o <= 1'b0;
              2'd1: ;
              2'd2: scl_oe_o <= 1'b1;
              2'd3: begin
                shreg <= {shreg[22:0], 1'b0};
                if (bitn == 3'd7) begin
                  bitn     <= '0;
                  state    <= S_ACK;
                  sda_oe_o <= 1'b0;
                end else begin
                  bitn     <= bitn + 3'd1;
                  sda_oe_o <= ~shreg[22];
                end
              end
            endcase
          end
        end
        S_ACK: begin
          if (tick) begin
            unique case (q)
              2'd0: scl_oe_o <= 1'b0;
              2'd1: ;
              2'd2: begin
                scl_oe_o <= 1'b1;
                if (sda_i) begin
                  err_o <= 1'b1;
                  abort <= 1'b1;
                end
              end
              2'd3: begin
                // A NACK still finishes the SCL-low quarter so STOP starts
                // with SCL low and cannot be mistaken for a repeated START.
                if (abort || byten == 2'd2) begin
                  state    <= S_STOP;
                  sda_oe_o <= 1'b1;
                end else begin
                  byten    <= byten + 2'd1;
                  state    <= S_BIT;
                  sda_oe_o <= ~shreg[23];
                end
              end
            endcase
          end
        end
        S_STOP: begin
          if (tick) begin
            unique case (q)
              2'd0: scl_oe_o <= 1'b0;
              2'd1: sda_oe_o <= 1'b0;
              2'd2: ;
              2'd3: state <= S_NEXT;
            endcase
          end
        end
        S_NEXT: begin
          bitn  <= '0;
          byten <= '0;
          abort <= 1'b0;
          if (seq && !abort && (32'(tbl_idx_o) + 32'd1 < TBL_LEN)) begin
            tbl_idx_o  <= tbl_idx_o + 8'd1;
            fetch_wait <= 1'b1;
            state      <= S_FETCH;
          end else begin
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            tbl_idx_o <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
